// File: rtl/input_irq_pkg.sv
// input_irq_pkg: shared FSM state type and 8-channel button index map for input_irq_controller.
package input_irq_pkg;

    typedef enum logic {
        IRQ_IDLE,
        IRQ_PRESENT
    } irq_state_e;

    localparam int CH_LEFT   = 0;
    localparam int CH_RIGHT  = 1;
    localparam int CH_DOWN   = 2;
    localparam int CH_UP     = 3;
    localparam int CH_SELECT = 4;
    localparam int CH_START  = 5;
    localparam int CH_A      = 6;
    localparam int CH_B      = 7;

endpackage

// File: rtl/input_irq_channel.sv
// input_irq_channel: 2-flop synchroniser, optional debounce (INPUT_IRQ_DEBOUNCE_EN) and registered rising-edge pulse.
module input_irq_channel #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic rise_o
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_cfg
        $error("DEBOUNCE_CYCLES must be in 1..255");
    end

    logic s1_q, s2_q, prev_q, rise_q, filt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            s1_q   <= btn_i;
            s2_q   <= s1_q;
            prev_q <= filt;
            rise_q <= filt & ~prev_q;
        end
    end

`ifdef INPUT_IRQ_DEBOUNCE_EN
    logic       filt_q, filt_d;
    logic [7:0] cnt_q, cnt_d;

    // Counter runs only while the input disagrees with the accepted level.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (s2_q != filt_q) begin
            if (cnt_q == 8'(DEBOUNCE_CYCLES - 1)) filt_d = s2_q;
            else cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt = filt_q;
`else
    assign filt = s2_q;
`endif

    assign rise_o = rise_q;

endmodule

// File: rtl/input_irq_controller.sv
// input_irq_controller: latches button rising edges and presents them one at a time, lowest channel first.
// Per-channel debounce is built only when INPUT_IRQ_DEBOUNCE_EN is defined.
module input_irq_controller
    import input_irq_pkg::*;
#(
    parameter int NUM_CH          = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         btn,
    input  logic [NUM_CH-1:0]         mask,
    input  logic                      irq_ack,
    output logic                      irq_valid,
    output logic [$clog2(NUM_CH)-1:0] irq_id,
    output logic [NUM_CH-1:0]         pending
);

    localparam int IW = $clog2(NUM_CH);

    if (NUM_CH < 2 || NUM_CH > 32) begin : g_bad_cfg
        $error("NUM_CH must be in 2..32");
    end

    irq_state_e        state_q, state_d;
    logic [IW-1:0]     id_q, id_d, sel;
    logic [NUM_CH-1:0] pend_q, pend_d, rise, clr;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        input_irq_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .btn_i (btn[c]),
            .rise_o(rise[c])
        );
    end

    always_comb begin
        sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (pend_q[i] && mask[i]) sel = IW'(i);
    end

    // A fresh edge on the acknowledged channel outranks the clear.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        clr     = (state_q == IRQ_PRESENT && irq_ack) ? NUM_CH'(1) << id_q : '0;
        if (state_q == IRQ_IDLE) begin
            if (|(pend_q & mask)) begin
                state_d = IRQ_PRESENT;
                id_d    = sel;
            end
        end else if (irq_ack) begin
            state_d = IRQ_IDLE;
        end
        pend_d = (pend_q & ~clr) | rise;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IRQ_IDLE;
            id_q    <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            pend_q  <= pend_d;
        end
    end

    assign irq_valid = (state_q == IRQ_PRESENT);
    assign irq_id    = id_q;
    assign pending   = pend_q;

endmodule
